// File: rtl/secded_decoder_pipe_pkg.sv
// secded_pkg: shared SECDED(72,64) constants, codeword type, position table and check/syndrome helpers
package secded_pkg;
  localparam int CW_W   = 72;
  localparam int DATA_W = 64;
  localparam int CHK_W  = 8;
  typedef logic [CW_W-1:0] codeword_t;
  typedef logic [DATA_W-1:0][6:0] pos_tab_t;
  // P(j): the (j+1)-th non-power-of-two Hamming position in 3..71
  function automatic pos_tab_t gen_pos_tab();
    pos_tab_t t;
    int j;
    t = '0;
    j = 0;
    for (int p = 3; p < CW_W; p++)
      if ((p & (p - 1)) != 0) begin
        t[j] = 7'(p);
        j++;
      end
    return t;
  endfunction
  localparam pos_tab_t P_TAB = gen_pos_tab();
  function automatic logic [6:0] calc_chk(logic [DATA_W-1:0] d);
    logic [6:0] c;
    c = '0;
    for (int j = 0; j < DATA_W; j++)
      for (int i = 0; i < 7; i++)
        if (P_TAB[j][i]) c[i] ^= d[j];
    return c;
  endfunction
  // Codeword bit index addressed by a nonzero syndrome, or -1 when it names no position
  function automatic int syn2idx(logic [6:0] s);
    int idx;
    idx = -1;
    for (int i = 0; i < 7; i++)
      if (s == 7'(1 << i)) idx = DATA_W + i;
    for (int j = 0; j < DATA_W; j++)
      if (s == P_TAB[j]) idx = j;
    return idx;
  endfunction
endpackage

// File: rtl/secded_decoder_pipe_err_cnt.sv
// secded_err_cnt: saturating event counter with synchronous clear (clear wins over increment)
//   clk, rst_n (async active-low), i_clr, i_inc -> o_cnt
module secded_err_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);
  logic [W-1:0] r_cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_inc && r_cnt != {W{1'b1}}) r_cnt <= r_cnt + W'(1);
  assign o_cnt = r_cnt;
endmodule

// File: rtl/secded_decoder_pipe.sv
// secded_decoder_pipe: two-stage valid/ready SECDED(72,64) decoder with saturating error counters
//   in_valid/in_ready/in_data: codeword input; out_valid/out_ready/out_data: corrected codeword output
//   single_error/double_error/error_detected/syndrome: status of the current output word
//   cnt_clr, single_cnt, double_cnt: error statistics; SECDED_ERR_LOG_EN adds log_valid/log_syndrome/log_data
module secded_decoder_pipe
  import secded_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CW_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW_W-1:0]  out_data,
  output logic             error_detected,
  output logic             single_error,
  output logic             double_error,
  output logic [CHK_W-1:0] syndrome,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] single_cnt,
  output logic [CNT_W-1:0] double_cnt
`ifdef SECDED_ERR_LOG_EN
  ,
  output logic             log_valid,
  output logic [CHK_W-1:0] log_syndrome,
  output logic [CW_W-1:0]  log_data
`endif
);
  logic       r_s1_valid, r_s1_p;
  codeword_t  r_s1_cw;
  logic [6:0] r_s1_s;
  logic       r_out_valid, r_single, r_double;
  codeword_t  r_out_data;
  logic [CHK_W-1:0] r_syn;
  logic       w_s2_load, w_s1_adv, w_xfer, w_hit, w_single, w_double;
  int         w_idx;
  logic [6:0] w_flip;
  codeword_t  w_mask;
  assign w_s2_load = !r_out_valid || out_ready;
  assign w_s1_adv  = r_s1_valid && w_s2_load;
  assign in_ready  = !r_s1_valid || w_s1_adv;
  assign w_xfer    = r_out_valid && out_ready;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_cw    <= '0;
      r_s1_s     <= '0;
      r_s1_p     <= 1'b0;
    end else if (in_ready) begin
      r_s1_valid <= in_valid;
      if (in_valid) begin
        r_s1_cw <= in_data;
        r_s1_s  <= calc_chk(in_data[DATA_W-1:0]) ^ in_data[70:64];
        r_s1_p  <= ^in_data;
      end
    end
  // Odd parity means one flipped bit: s==0 points at the parity bit itself, otherwise s must name a position
  assign w_idx    = syn2idx(r_s1_s);
  assign w_hit    = w_idx >= 0;
  assign w_single = r_s1_p && (r_s1_s == '0 || w_hit);
  assign w_double = r_s1_s != '0 && (!r_s1_p || !w_hit);
  assign w_flip   = r_s1_s == '0 ? 7'd71 : w_idx[6:0];
  assign w_mask   = w_single ? codeword_t'(1) << w_flip : '0;
`ifdef SECDED_ERR_LOG_EN
  codeword_t r_out_raw;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_out_raw <= '0;
    else if (w_s1_adv) r_out_raw <= r_s1_cw;
`endif
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_single    <= 1'b0;
      r_double    <= 1'b0;
      r_syn       <= '0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_data <= r_s1_cw ^ w_mask;
        r_single   <= w_single;
        r_double   <= w_double;
        r_syn      <= {r_s1_p, r_s1_s};
      end
    end
  assign out_valid      = r_out_valid;
  assign out_data       = r_out_data;
  assign single_error   = r_single;
  assign double_error   = r_double;
  assign error_detected = r_single | r_double;
  assign syndrome       = r_syn;
  secded_err_cnt #(.W(CNT_W)) u_single_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (cnt_clr),
    .i_inc (w_xfer && r_single),
    .o_cnt (single_cnt)
  );
  secded_err_cnt #(.W(CNT_W)) u_double_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (cnt_clr),
    .i_inc (w_xfer && r_double),
    .o_cnt (double_cnt)
  );
`ifdef SECDED_ERR_LOG_EN
  logic             r_log_valid;
  logic [CHK_W-1:0] r_log_syn;
  codeword_t        r_log_data;
  // Sticky capture of the first erroneous word as received, before correction
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_log_valid <= 1'b0;
      r_log_syn   <= '0;
      r_log_data  <= '0;
    end else if (cnt_clr) begin
      r_log_valid <= 1'b0;
      r_log_syn   <= '0;
      r_log_data  <= '0;
    end else if (w_xfer && (r_single || r_double) && !r_log_valid) begin
      r_log_valid <= 1'b1;
      r_log_syn   <= r_syn;
      r_log_data  <= r_out_raw;
    end
  assign log_valid    = r_log_valid;
  assign log_syndrome = r_log_syn;
  assign log_data     = r_log_data;
`endif
endmodule

// File: doc/secded_decoder_pipe.md
Name: secded_decoder_pipe

Overview:
- Registered, flow-controlled SECDED(72,64) decoder; the receiving end of the SECDED_Encoder_comb → channel path.
- Accepts 72-bit codewords over a valid/ready handshake and computes the syndrome in stage 1.
- Corrects or flags errors in stage 2 and emits the corrected codeword plus error status.
- Keeps saturating single- and double-error statistics counters for memory/link health monitoring.

Parameters:
- CNT_W, 16, width of the saturating single/double error counters (≥1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  codeword on in_data is valid.
- in_ready  out  1  decoder can accept a codeword this cycle.
- in_data  in  72  received codeword.
- out_valid  out  1  out_data and flags are valid.
- out_ready  in  1  downstream accepts the output this cycle.
- out_data  out  72  corrected codeword; data in [63:0].
- error_detected  out  1  single_error | double_error for the current output.
- single_error  out  1  one-bit error found and corrected.
- double_error  out  1  uncorrectable error.
- syndrome  out  8  {overall parity, s[6:0]} of the current output.
- cnt_clr  in  1  synchronous clear of both counters.
- single_cnt  out  CNT_W  saturating count of single errors.
- double_cnt  out  CNT_W  saturating count of uncorrectable errors.

Behaviour:
- Codeword layout (fixed, identical to the encoder):
  - [63:0] = data; data bit j sits at Hamming position P(j), the (j+1)-th integer in 3..71 that is not a power of two.
  - [70:64] = check bits c0..c6; ci = XOR of data bits whose P(j) has bit i set; check bit ci sits at position 2^i.
  - [71] = overall parity, XOR of bits [70:0].
- Stage 1 (syndrome):
  - s[6:0] = recomputed check bits XOR received [70:64].
  - p = XOR of all 72 bits.
  - Register the codeword, s and p.
- Stage 2 (classify/correct):
  - s==0, p==0: clean; data passes through.
  - p==1, s==0: single error in bit 71; flip it.
  - p==1, s==2^i: single error in check bit 64+i; flip it.
  - p==1, s equal to some P(j): single error in data bit j; flip it.
  - p==1, s>71: double_error; no correction.
  - p==0, s!=0: double_error; codeword forwarded unmodified.
- Latency: 2 cycles from an accepted input to out_valid, given out_ready held high. Throughput 1 word/cycle.
- Handshake:
  - Transfer occurs on a cycle with valid && ready.
  - Stage k advances when its downstream slot is empty or is being drained. in_ready = !s1_valid || s1_advance.
  - While out_valid && !out_ready, out_data, flags and syndrome hold stable.
  - in_ready is combinational from out_ready; no combinational path from in_valid to out_valid.
- Counters:
  - Increment by 1 on each output transfer (out_valid && out_ready) flagged single/double.
  - Saturate at 2^CNT_W−1; never wrap.
  - cnt_clr has priority over a simultaneous increment; the result is 0.
- Reset: all valids, flags, syndrome, out_data and counters go to 0. Words in flight at reset are dropped. in_ready = 1 in the first cycle after reset release.

Optional Feature:
- Macro: SECDED_ERR_LOG_EN.
- With it: extra outputs log_valid (1), log_syndrome (8) and log_data (72).
  - The first detected error's raw received codeword and syndrome are captured at output transfer and held sticky.
  - Cleared by cnt_clr or reset.
  - A later error does not overwrite the log.
- Without it: these ports and registers do not exist.

Decomposition:
- Package secded_pkg holds:
  - CW_W=72, DATA_W=64, CHK_W=8.
  - typedef codeword_t.
  - A function mapping syndrome to a bit index (returns −1 for invalid).
  - The position table P(j).
  - The check-bit computation function, shared with the encoder.
- One sub-module: secded_err_cnt, the saturating counter with clear, instantiated twice.

Test Plan:
- Clean word:
  - Stimulus: encode 0xDEADBEEF_CAFECAFE, no flips.
  - Response: 2 cycles later out_data[63:0]=0xDEADBEEF_CAFECAFE, all flags 0, syndrome 0x00.
- Data bit 0 flipped:
  - Stimulus: encoded 0x12345678_9ABCDEF0 with bit 0 flipped.
  - Response: out_data[63:0]=0x12345678_9ABCDEF0, single_error=1, syndrome 0x83 (p=1, s=3), single_cnt=1.
- Double flip:
  - Stimulus: bits 0 and 5 flipped.
  - Response: double_error=1, single_error=0, data forwarded unmodified, double_cnt=1.
- Parity bit 71 flipped:
  - Response: single_error=1, syndrome 0x80, data correct.
- Backpressure:
  - Stimulus: stream 4 words, out_ready=0 for 3 cycles.
  - Response: in_ready drops after 2 words accepted; outputs stable while stalled; all 4 words delivered in order.
- Counter saturation and reset mid-stream:
  - Stimulus: CNT_W=2, 5 single errors, then cnt_clr in the same cycle as an error.
  - Response: single_cnt stops at 3, then reads 0 after the clear.
  - Stimulus: assert rst_n low mid-stream.
  - Response: out_valid=0 immediately; counters 0.
